// File: rtl/control_unit_pkg.sv
// Shared encodings for the decode-stage main decoder: RV32 opcodes, ALU classes
// and the packed bundle of datapath control strobes.
package control_unit_pkg;

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALUOP_W  = 2;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_JUMP   = 2'b11;

    typedef struct packed {
        logic               branch;
        logic               reg_write;
        logic               mem_read;
        logic               mem_to_reg;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               alu_src;
        logic               is_imm;
    } ctrl_t;

endpackage

// File: rtl/control_unit_decode_comb.sv
// Pure combinational opcode/funct3 to control-strobe decoder; illegal flags
// unsupported opcodes and funct3 values that are reserved for the opcode.
module control_decode_comb
    import control_unit_pkg::*;
(
    input  logic [OPC_W-1:0]    opcode_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    output ctrl_t               ctrl_c_o,
    output logic                illegal_c_o
);

    // Strobes follow the opcode row even when funct3 makes the instruction illegal.
    always_comb begin
        ctrl_c_o    = '0;
        illegal_c_o = 1'b0;
        case (opcode_i)
            OPC_R: begin
                ctrl_c_o.reg_write = 1'b1;
                ctrl_c_o.alu_op    = ALUOP_FUNCT;
            end
            OPC_OPIMM: begin
                ctrl_c_o.reg_write = 1'b1;
                ctrl_c_o.alu_op    = ALUOP_FUNCT;
                ctrl_c_o.alu_src   = 1'b1;
                ctrl_c_o.is_imm    = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_c_o.reg_write  = 1'b1;
                ctrl_c_o.mem_read   = 1'b1;
                ctrl_c_o.mem_to_reg = 1'b1;
                ctrl_c_o.alu_op     = ALUOP_ADD;
                ctrl_c_o.alu_src    = 1'b1;
                ctrl_c_o.is_imm     = 1'b1;
                illegal_c_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                              (funct3_i == 3'b111);
            end
            OPC_STORE: begin
                ctrl_c_o.mem_write = 1'b1;
                ctrl_c_o.alu_op    = ALUOP_ADD;
                ctrl_c_o.alu_src   = 1'b1;
                illegal_c_o = (funct3_i > 3'b010);
            end
            OPC_BRANCH: begin
                ctrl_c_o.branch = 1'b1;
                ctrl_c_o.alu_op = ALUOP_BRANCH;
                illegal_c_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end
            OPC_JALR: begin
                ctrl_c_o.branch = 1'b1;
                ctrl_c_o.alu_op = ALUOP_JUMP;
                illegal_c_o = (funct3_i != 3'b000);
            end
            OPC_JAL: begin
                ctrl_c_o.branch = 1'b1;
                ctrl_c_o.alu_op = ALUOP_JUMP;
            end
            default: begin
                illegal_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Decode-stage main decoder: combinational decode followed by one register
// stage so the strobes line up with the decode/execute boundary.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNCT3_W-1:0] funct3,
    output logic                branch,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                mem_write,
    output logic                alu_src,
    output logic                is_imm,
    output logic                illegal
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  illegal_d;
    logic  illegal_q;

    control_decode_comb u_decode (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .ctrl_c_o    (ctrl_d),
        .illegal_c_o (illegal_d)
    );

    // Reset forces a NOP (all strobes clear) and wins over decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign branch     = ctrl_q.branch;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_op     = ctrl_q.alu_op;
    assign mem_write  = ctrl_q.mem_write;
    assign alu_src    = ctrl_q.alu_src;
    assign is_imm     = ctrl_q.is_imm;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected strobe vectors are queued as
// stimulus is applied and popped after the edge that should produce them.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch, reg_write, mem_read, mem_to_reg, mem_write, alu_src, is_imm, illegal;
    logic [1:0] alu_op;

    // {branch, reg_write, mem_read, mem_to_reg, alu_op, mem_write, alu_src, is_imm, illegal}
    logic [9:0] obs;
    logic [9:0] exp_q[$];
    logic [9:0] last_exp;
    int total;
    int bad;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .branch     (branch),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .is_imm     (is_imm),
        .illegal    (illegal)
    );

    assign obs = {branch, reg_write, mem_read, mem_to_reg, alu_op, mem_write, alu_src, is_imm, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written straight from the opcode table.
    function automatic logic [9:0] model(input logic r, input logic [6:0] op, input logic [2:0] f3);
        logic [8:0] s;
        logic       ill;
        if (r) return 10'b0;
        ill = 1'b0;
        case (op)
            7'b0110011: s = 9'b0_1_0_0_10_0_0_0;
            7'b0010011: s = 9'b0_1_0_0_10_0_1_1;
            7'b0000011: begin s = 9'b0_1_1_1_00_0_1_1; ill = (f3 == 3) || (f3 == 6) || (f3 == 7); end
            7'b0100011: begin s = 9'b0_0_0_0_00_1_1_0; ill = (f3 >= 3); end
            7'b1100011: begin s = 9'b1_0_0_0_01_0_0_0; ill = (f3 == 2) || (f3 == 3); end
            7'b1100111: begin s = 9'b1_0_0_0_11_0_0_0; ill = (f3 != 0); end
            7'b1101111: s = 9'b1_0_0_0_11_0_0_0;
            default:    begin s = 9'b0; ill = 1'b1; end
        endcase
        return {s, ill};
    endfunction

    // Apply one cycle of stimulus, queue its expectation, sample #1 after the edge.
    task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3);
        rst    = r;
        opcode = op;
        funct3 = f3;
        exp_q.push_back(model(r, op, f3));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 7'b0110011, 3'b000);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset[%0d] obs=%b exp=%b", i, obs, e); end
        end
        drive(1'b0, 7'b0110011, 3'b000);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_release obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_rtype();
        logic [9:0] e;
        drive(1'b0, 7'b0110011, 3'b001);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rtype obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_load();
        logic [9:0] e;
        drive(1'b0, 7'b0000011, 3'b001);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL load_ok obs=%b exp=%b", obs, e); end
        drive(1'b0, 7'b0000011, 3'b111);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL load_bad_f3 obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_store();
        logic [9:0] e;
        drive(1'b0, 7'b0100011, 3'b000);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL store obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_branch_jump();
        logic [9:0] e;
        drive(1'b0, 7'b1100011, 3'b001);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL branch obs=%b exp=%b", obs, e); end
        drive(1'b0, 7'b1100111, 3'b001);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL jalr_bad_f3 obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_illegal_opcode();
        logic [9:0] e;
        drive(1'b0, 7'b0000000, 3'b000);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL illegal_opc obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] e;
        drive(1'b0, 7'b0000011, 3'b010);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL mid_load obs=%b exp=%b", obs, e); end
        drive(1'b1, 7'b0000011, 3'b010);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL mid_reset obs=%b exp=%b", obs, e); end
    endtask

    task automatic test_hold();
        logic [9:0] e;
        drive(1'b0, 7'b1101111, 3'b101);
        e = exp_q.pop_front();
        last_exp = e;
        total++;
        if (obs !== e) begin bad++; $display("FAIL hold_setup obs=%b exp=%b", obs, e); end
        opcode = 7'b0100011;
        funct3 = 3'b111;
        #3;
        total++;
        if (obs !== last_exp) begin bad++; $display("FAIL hold_between_edges obs=%b exp=%b", obs, last_exp); end
        exp_q.push_back(model(1'b0, opcode, funct3));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL hold_next_edge obs=%b exp=%b", obs, e); end
    endtask

    // Every legal opcode against every funct3, then random opcodes, back to back.
    task automatic test_back_to_back();
        logic [6:0] opcs [7];
        logic [9:0] e;
        opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011; opcs[3] = 7'b0100011;
        opcs[4] = 7'b1100011; opcs[5] = 7'b1100111; opcs[6] = 7'b1101111;
        for (int o = 0; o < 7; o++) begin
            for (int f = 0; f < 8; f++) begin
                drive(1'b0, opcs[o], 3'(f));
                e = exp_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL sweep op=%b f3=%0d obs=%b exp=%b", opcs[o], f, obs, e);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL random[%0d] op=%b f3=%b obs=%b exp=%b", i, opcode, funct3, obs, e);
            end
        end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL queue_drain left=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch_jump();
        test_illegal_opcode();
        test_reset_midstream();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
